// File: rtl/counter_sequencer_if.sv
// Host-side control and status bundle for the counter sequencer.
// The host (master) drives the run controls and reads back the count and status.
interface counter_sequencer_if #(
    parameter int WIDTH = 2,
    parameter int WRAPW = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic [WRAPW-1:0] n_wraps;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             wrap;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, stop, pause, dir, limit, n_wraps,
        input  count, busy, wrap, done, state
    );

    modport slave (
        input  start, stop, pause, dir, limit, n_wraps,
        output count, busy, wrap, done, state
    );
endinterface

// File: rtl/counter_sequencer.sv
// Sequencer for a modulo-(limit+1) up/down counter.
// A run is loaded on start, steps once per cycle unless paused, and ends
// either on stop (silently) or after n_wraps complete cycles (done pulse).
// Every output is a register or a decode of the state register.
module counter_sequencer #(
    parameter int WIDTH = 2,
    parameter int WRAPW = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    counter_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic             dir_q;
    logic [WRAPW-1:0] nw_q;
    logic [WRAPW-1:0] wrap_cnt;
    logic             wrap_q;
    logic             done_q;

    // Next-step helpers for the running counter.
    logic             at_term;      // current count is the wrap point for dir_q
    logic [WIDTH-1:0] step_val;     // count after a non-wrapping step
    logic [WIDTH-1:0] wrap_val;     // count after a wrapping step
    logic [WRAPW-1:0] wrap_cnt_inc;
    logic             wrap_sat;     // free-run wrap counter has pinned at all-ones

    // Decode the step result from the latched direction and terminal value.
    always_comb begin
        at_term      = 1'b0;
        step_val     = count_q;
        wrap_val     = '0;
        wrap_cnt_inc = wrap_cnt + 1'b1;
        wrap_sat     = &wrap_cnt;
        if (dir_q) begin
            at_term  = (count_q == '0);
            step_val = count_q - 1'b1;
            wrap_val = limit_q;
        end else begin
            // Equality compare only: the count is loaded at 0 and can never
            // pass limit_q, so no range check is needed.
            at_term  = (count_q == limit_q);
            step_val = count_q + 1'b1;
            wrap_val = '0;
        end
    end

    // Control FSM; also owns the counter datapath and the status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            limit_q  <= '0;
            dir_q    <= 1'b0;
            nw_q     <= '0;
            wrap_cnt <= '0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Pulses default low; they are raised only on the edge that earns them.
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // count keeps its last value; stop and pause are don't-care here.
                    if (bus.start) begin
                        limit_q  <= bus.limit;
                        dir_q    <= bus.dir;
                        nw_q     <= bus.n_wraps;
                        wrap_cnt <= '0;
                        count_q  <= bus.dir ? bus.limit : '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        // Abort beats both pause and a coincident wrap.
                        count_q <= '0;
                        state_q <= IDLE;
                    end else if (!bus.pause) begin
                        if (at_term) begin
                            count_q <= wrap_val;
                            wrap_q  <= 1'b1;
                            if (nw_q == '0) begin
                                // Free-run: count wraps but never complete.
                                if (!wrap_sat) wrap_cnt <= wrap_cnt_inc;
                            end else begin
                                wrap_cnt <= wrap_cnt_inc;
                                if (wrap_cnt_inc == nw_q) begin
                                    state_q <= DONE;
                                    done_q  <= 1'b1;
                                end
                            end
                        end else begin
                            count_q <= step_val;
                        end
                    end
                end
                DONE: begin
                    // One-cycle completion state; count holds the final wrapped value.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.wrap  = wrap_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: reset, up/down runs, pause,
// stop priority, limit=0, restart-while-running and free-run saturation.
module tb_counter_sequencer;

    localparam int WIDTH = 2;
    localparam int WRAPW = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    counter_sequencer_if #(.WIDTH(WIDTH), .WRAPW(WRAPW)) bus ();

    counter_sequencer #(.WIDTH(WIDTH), .WRAPW(WRAPW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int cnt, input int st,
                           input int wr, input int dn);
        chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
        chk({tag, ".state"}, 32'(bus.state), 32'(st));
        chk({tag, ".busy"},  32'(bus.busy),  32'(st == 1));
        chk({tag, ".wrap"},  32'(bus.wrap),  32'(wr));
        chk({tag, ".done"},  32'(bus.done),  32'(dn));
    endtask

    task automatic launch(input int lim, input logic d, input int nw);
        bus.limit   = WIDTH'(lim);
        bus.dir     = d;
        bus.n_wraps = WRAPW'(nw);
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    initial begin
        int up_cnt [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        int model;
        int guard;
        bit wr;

        checks   = 0;
        failures = 0;
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.dir = 0;
        bus.limit = '0; bus.n_wraps = '0;
        rst_n = 1'b0;
        #12;
        chk_out("reset", 0, 0, 0, 0);
        // Controls are ignored in IDLE apart from start.
        bus.stop = 1; bus.pause = 1;
        rst_n = 1'b1;
        tick();
        chk_out("idle_ign", 0, 0, 0, 0);
        bus.stop = 0; bus.pause = 0;

        // Up run, limit=3, two wraps. Mid-run changes to limit/dir/n_wraps
        // and a start pulse must have no effect.
        launch(3, 1'b0, 2);
        chk_out("up_load", 0, 1, 0, 0);
        bus.limit = 2'd1; bus.dir = 1'b1; bus.n_wraps = 4'd1;
        for (int i = 0; i < 8; i++) begin
            bus.start = (i == 1);
            tick();
            chk_out($sformatf("up_e%0d", i + 1), up_cnt[i], (i == 7) ? 2 : 1,
                    int'(i == 3 || i == 7), int'(i == 7));
        end
        bus.start = 0;
        tick();
        chk_out("up_end", 0, 0, 0, 0);

        // Down run, limit=2, one wrap.
        launch(2, 1'b1, 1);
        chk_out("dn_load", 2, 1, 0, 0);
        tick(); chk_out("dn_e2", 1, 1, 0, 0);
        tick(); chk_out("dn_e3", 0, 1, 0, 0);
        tick(); chk_out("dn_e4", 2, 2, 1, 1);
        tick(); chk_out("dn_idle", 2, 0, 0, 0);
        tick(); chk_out("dn_hold", 2, 0, 0, 0);

        // limit=0, three wraps: every step wraps.
        launch(0, 1'b0, 3);
        chk_out("z_load", 0, 1, 0, 0);
        tick(); chk_out("z_w1", 0, 1, 1, 0);
        tick(); chk_out("z_w2", 0, 1, 1, 0);
        tick(); chk_out("z_w3", 0, 2, 1, 1);
        tick(); chk_out("z_end", 0, 0, 0, 0);

        // Free-run with pause, then many wraps (past wrap-count saturation),
        // then stop+pause on the terminal count.
        launch(3, 1'b0, 0);
        chk_out("p_load", 0, 1, 0, 0);
        tick(); chk_out("p_c1", 1, 1, 0, 0);
        bus.pause = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out($sformatf("p_hold%0d", i), 1, 1, 0, 0);
        end
        bus.pause = 0;
        tick(); chk_out("p_resume", 2, 1, 0, 0);
        model = 2;
        for (int i = 0; i < 80; i++) begin
            wr = (model == 3);
            model = wr ? 0 : model + 1;
            tick();
            chk_out($sformatf("fr%0d", i), model, 1, int'(wr), 0);
        end
        guard = 0;
        while (model != 3 && guard < 8) begin
            model = model + 1;
            guard++;
            tick();
        end
        chk("fr_term.count", 32'(bus.count), 32'd3);
        bus.stop = 1; bus.pause = 1;
        tick(); chk_out("stop_pri", 0, 0, 0, 0);
        bus.stop = 0; bus.pause = 0;
        tick(); chk_out("stop_after", 0, 0, 0, 0);

        // Asynchronous reset mid-run at count=2, seen before the next edge.
        launch(3, 1'b0, 0);
        tick(); tick();
        chk("ar_pre.count", 32'(bus.count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        tick();
        chk_out("rst_hold", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_out("rst_rel", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
